// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative multiply/divide behind valid/ready handshakes
//
// Purpose:
//   Executes add/sub/logic/compare in one cycle and MUL/MULHU/DIVU/REMU iteratively
//   (one shift-add or restoring-subtract step per cycle). One operation in flight.
//   Optional feature macro: ALU_MC_DIV_EN (defined -> DIVU/REMU implemented;
//   undefined -> divider omitted, 1110/1111 complete in one cycle with err=1).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands/op valid            in_ready   block can accept (IDLE)
//   a, b       operands (WIDTH)             ALUop      operation select (4 bits)
//   out_valid  result valid (DONE)          out_ready  consumer takes result
//   result     registered result            flag       1 iff result == 0
//   err        1 iff op unsupported in this build

module alu_mc #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic             sel_hi_q;     // result taken from acc (MULHU/REMU) rather than lo
    logic [WIDTH-1:0] acc_q;        // product high half / partial remainder
    logic [WIDTH-1:0] lo_q;         // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] result_q;
    logic             flag_q;
    logic             err_q;

    logic             is_iter;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic [WIDTH-1:0] acc_step, lo_step, iter_res;
    logic [WIDTH:0]   mul_sum;

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] b_q;
    logic             div_q;
    logic [WIDTH:0]   div_shift, div_trial;
    assign is_iter = (ALUop[3:2] == 2'b11);
`else
    assign is_iter = (ALUop[3:1] == 3'b110);
`endif

    // Single-cycle operations, computed straight from the inputs on accept.
    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (ALUop)
            4'b0000: single_res = a + b;
            4'b0001: single_res = a - b;
            4'b0100: single_res = a & b;
            4'b0101: single_res = a | b;
            4'b0110: single_res = a ^ b;
            4'b0111: single_res = ~(a | b);
            4'b1000: single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1001: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: single_err = 1'b1;
        endcase
    end

    // One iteration step. Multiply: add multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole product right.
    assign mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};

`ifdef ALU_MC_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and keep
    // the trial subtraction only if it did not borrow (bit WIDTH clear).
    // With b=0 every trial succeeds, giving quotient all-ones and remainder a.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};

    always_comb begin
        acc_step = mul_sum[WIDTH:1];
        lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (div_q) begin
            acc_step = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end
    end
`else
    assign acc_step = mul_sum[WIDTH:1];
    assign lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif

    // The last step's output goes straight into result so DONE follows immediately.
    assign iter_res = sel_hi_q ? acc_step : lo_step;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)          state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: if (out_ready)         state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign err    = err_q;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            sel_hi_q <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            b_q      <= '0;
            div_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        sel_hi_q <= ALUop[0];
                        acc_q    <= '0;
                        lo_q     <= b;
`ifdef ALU_MC_DIV_EN
                        b_q      <= b;
                        div_q    <= ALUop[1];
                        if (ALUop[1]) lo_q <= a;
`endif
                        if (is_iter) begin
                            cnt_q <= CNT_W'(WIDTH);
                        end else begin
                            cnt_q    <= '0;
                            result_q <= single_res;
                            flag_q   <= (single_res == '0);
                            err_q    <= single_err;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= iter_res;
                        flag_q   <= (iter_res == '0);
                        err_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard testbench for alu_mc (WIDTH=32)

module tb_alu_mc;

    localparam int W = 32;

`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag;
    logic         err;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .err       (err)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         flag;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y);
        exp_t           e;
        logic [2*W-1:0] p;
        p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res = '0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            4'h0: e.res = x + y;
            4'h1: e.res = x - y;
            4'h4: e.res = x & y;
            4'h5: e.res = x | y;
            4'h6: e.res = x ^ y;
            4'h7: e.res = ~(x | y);
            4'h8: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'h9: e.res = (x < y) ? W'(1) : W'(0);
            4'hC: begin e.res = p[W-1:0];   e.lat = W + 1; end
            4'hD: begin e.res = p[2*W-1:W]; e.lat = W + 1; end
            4'hE: if (DIV_EN) begin e.res = (y == 0) ? {W{1'b1}} : x / y; e.lat = W + 1; end
                  else e.err = 1'b1;
            4'hF: if (DIV_EN) begin e.res = (y == 0) ? x : x % y; e.lat = W + 1; end
                  else e.err = 1'b1;
            default: e.err = 1'b1;
        endcase
        e.flag = (e.res == '0);
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        ALUop    = op;
        a        = x;
        b        = y;
        sb.push_back(model(op, x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid; cyc counts from 1 at the first negedge after accept.
    task automatic wait_out(output int cyc, output bit to, output bit rdy);
        cyc = 1;
        to  = 1'b0;
        rdy = 1'b0;
        while (out_valid !== 1'b1 && !to) begin
            if (in_ready !== 1'b0) rdy = 1'b1;
            if (cyc >= 200) to = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (in_ready !== 1'b0) rdy = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; ALUop = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, flag, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got in_ready=%b out_valid=%b result=%h flag=%b err=%b exp 1 0 0 0 0",
                     in_ready, out_valid, result, flag, err);
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0]   ops[10] = '{4'h0, 4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'h2, 4'hB};
        logic [W-1:0] av[10]  = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'hF0F0F0F0, 32'h0F000000,
                                  32'h0, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd9};
        logic [W-1:0] bv[10]  = '{32'd1, 32'd3, 32'd1, 32'h0FF00FF0, 32'h00000003,
                                  32'h0, 32'd1, 32'd1, 32'd7, 32'd9};
        exp_t e; int cyc; bit to, rdy;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_out(cyc, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat || rdy) begin
                errors++;
                $display("FAIL single[%0d] op=%h got res=%h flag=%b err=%b lat=%0d rdy=%b to=%b exp res=%h flag=%b err=%b lat=%0d",
                         i, ops[i], result, flag, err, cyc, rdy, to, e.res, e.flag, e.err, e.lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mul();
        logic [3:0]   ops[6] = '{4'hC, 4'hD, 4'hC, 4'hD, 4'hC, 4'hD};
        logic [W-1:0] av[6]  = '{32'h10000, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF, $urandom, $urandom};
        logic [W-1:0] bv[6]  = '{32'h10001, 32'h10001, 32'hFFFFFFFF, 32'hFFFFFFFF, $urandom, $urandom};
        exp_t e; int cyc; bit to, rdy;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_out(cyc, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat || rdy) begin
                errors++;
                $display("FAIL mul[%0d] op=%h a=%h b=%h got res=%h flag=%b err=%b lat=%0d rdy=%b to=%b exp res=%h flag=%b err=%b lat=%0d",
                         i, ops[i], av[i], bv[i], result, flag, err, cyc, rdy, to, e.res, e.flag, e.err, e.lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic [3:0]   ops[6] = '{4'hE, 4'hF, 4'hE, 4'hF, 4'hE, 4'hF};
        logic [W-1:0] av[6]  = '{32'd100, 32'd100, 32'd5, 32'd5, $urandom, $urandom};
        logic [W-1:0] bv[6]  = '{32'd7, 32'd7, 32'd0, 32'd0, $urandom_range(1, 65535), $urandom_range(1, 65535)};
        exp_t e; int cyc; bit to, rdy;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], av[i], bv[i]);
            wait_out(cyc, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat || rdy) begin
                errors++;
                $display("FAIL div[%0d] op=%h a=%h b=%h got res=%h flag=%b err=%b lat=%0d rdy=%b to=%b exp res=%h flag=%b err=%b lat=%0d",
                         i, ops[i], av[i], bv[i], result, flag, err, cyc, rdy, to, e.res, e.flag, e.err, e.lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t e; int cyc; bit to, rdy, bad;
        out_ready = 1'b0;
        send(4'h6, 32'h5A5A5A5A, 32'h5A5A5A5A);
        wait_out(cyc, to, rdy);
        e = sb.pop_front();
        checks++;
        if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat) begin
            errors++;
            $display("FAIL bp_first got res=%h flag=%b err=%b lat=%0d to=%b exp res=%h flag=%b err=%b lat=%0d",
                     result, flag, err, cyc, to, e.res, e.flag, e.err, e.lat);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            ALUop    = 4'h0;
            a        = 32'd1;
            b        = 32'd1;
            @(negedge clk);
            if ({out_valid, in_ready, result, flag, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b1, 1'b0}) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got out_valid=%b in_ready=%b res=%h flag=%b err=%b exp 1 0 0 1 0",
                     out_valid, in_ready, result, flag, err);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_ignored got out_valid=1 from ignored pulse exp 0");
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e; int cyc; bit to, rdy, bad;
        send(4'hC, 32'h10000, 32'h10001);
        sb.delete();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, flag, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid got in_ready=%b out_valid=%b result=%h flag=%b err=%b exp 1 0 0 0 0",
                     in_ready, out_valid, result, flag, err);
        end
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_stale got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
        end
        send(4'h0, 32'd2, 32'd3);
        wait_out(cyc, to, rdy);
        e = sb.pop_front();
        checks++;
        if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat || result !== 32'd5) begin
            errors++;
            $display("FAIL rst_add got res=%h flag=%b err=%b lat=%0d to=%b exp res=%h flag=%b err=%b lat=%0d",
                     result, flag, err, cyc, to, e.res, e.flag, e.err, e.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes[13] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                                  4'hC, 4'hD, 4'hE, 4'hF, 4'h3};
        logic [3:0] op; logic [W-1:0] x, y;
        exp_t e; int cyc; bit to, rdy;
        for (int i = 0; i < 20; i++) begin
            op = codes[$urandom_range(0, 12)];
            x  = $urandom;
            y  = (i % 4 == 0) ? x : $urandom;
            send(op, x, y);
            wait_out(cyc, to, rdy);
            e = sb.pop_front();
            checks++;
            if (to || {result, flag, err} !== {e.res, e.flag, e.err} || cyc != e.lat || rdy) begin
                errors++;
                $display("FAIL b2b[%0d] op=%h a=%h b=%h got res=%h flag=%b err=%b lat=%0d rdy=%b to=%b exp res=%h flag=%b err=%b lat=%0d",
                         i, op, x, y, result, flag, err, cyc, rdy, to, e.res, e.flag, e.err, e.lat);
            end
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got in_ready=%b out_valid=%b exp 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
